multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle datapath. Decodes the instruction opcode and sequences every datapath enable across fetch, decode, execute, memory and write-back. It is the producer side of the ALUOp interface: it drives the 2-bit ALUOp that the ALU control decoder combines with the funct field. One instruction is in flight at a time. The FSM stalls on instruction and data memory through a ready handshake.

## Interface
Parameters:
- none; opcodes and ALUOp codes are package constants

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- Opcode  in  6  instr[31:26], valid from DECODE onward (IR contents)
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if Zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  write-back source: 1 = MDR, 0 = ALUOut
- IRWrite  out  1  instruction register load
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  out  2  00 add, 01 sub, 10 use funct
- ALUSrcA  out  1  0 = PC, 1 = A register
- ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2
- RegWrite  out  1  register file write
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state_o  out  4  current state, for debug

## Operation
- Moore FSM with a 4-bit state register. Outputs are decoded combinationally from the state.
- The PCWrite/IRWrite terms in FETCH are additionally gated by mem_ready.
- Any output not listed for a state is 0.

States (encoding) and asserted outputs:
- FETCH(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite only when mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on Opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000000 → EXECUTE
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC (only with macro, see Configuration)
  - anything else → FETCH, with illegal_op=1 during this DECODE cycle
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ(3): MemRead, IorD=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB(4): RegWrite, MemtoReg=1, RegDst=0. Go to FETCH.
- MEM_WRITE(5): MemWrite, IorD=1. Hold until mem_ready, then go to FETCH.
- EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB(7): RegWrite, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Go to FETCH.
- JUMP(9): PCWrite, PCSource=10. Go to FETCH.
- ADDI_EXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
- ADDI_WB(11): RegWrite, RegDst=0, MemtoReg=0. Go to FETCH.
- Unused encodings 12–15: all outputs 0; next state FETCH.

## Timing
- While rst_n=0 at a clock edge, the state loads FETCH. All outputs are forced 0 combinationally while rst_n=0.
- First cycle after rst_n rises: state FETCH, MemRead=1.
- Reset asserted mid-instruction aborts it at the next edge. No partial writes occur after that edge.
- Latency in cycles, FETCH through last state, with mem_ready held 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4
  - Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- MemRead and MemWrite stay asserted and stable for the whole stall.
- Opcode is sampled only in DECODE and MEM_ADDR. Changes at other times have no effect.
- illegal_op is high for exactly one cycle per illegal instruction.

## Configuration
- MULTICYCLE_ADDI_EN defined:
  - Opcode 001000 dispatches to ADDI_EXEC.
  - States 10 and 11 exist.
- MULTICYCLE_ADDI_EN undefined:
  - 001000 is illegal: DECODE goes to FETCH with an illegal_op pulse.
  - Encodings 10 and 11 behave as unused.

## Structure
- Shared package `mc_pkg` holds:
  - state enum (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - PCSource and ALUSrcB select constants
- ALUControl imports the same ALUOp constants.
- One natural sub-module: `mc_out_decode`, a purely combinational state-to-outputs decoder. The top module keeps the state register and next-state logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → all outputs 0 during reset; next cycle state_o=0, MemRead=1.
- R-type add (Opcode 000000), mem_ready=1 → states 0,1,6,7,0; ALUOp=10 in state 6; RegWrite=1 and RegDst=1 in state 7.
- lw with mem_ready low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0; MemRead and IorD=1 held throughout state 3.
- beq with Zero=1, then with Zero=0 → ALUOp=01 and PCWriteCond=1 in state 8 in both cases; 3-cycle instruction.
- Opcode 111111 → DECODE returns to FETCH; illegal_op pulses 1 cycle; RegWrite and MemWrite never asserted.
- addi (001000) with and without MULTICYCLE_ADDI_EN:
  - defined: states 0,1,10,11,0
  - undefined: illegal_op pulse, return to FETCH.
- Bonus: rst_n=0 during MEM_WRITE stall → MemWrite drops to 0 immediately; state_o=0 after the edge.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multicycle control FSM: state
//               encoding, opcodes, ALUOp / PCSource / ALUSrcB select codes,
//               and the packed control-word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // 4-bit state encoding; 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp codes, shared with the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Datapath control word produced by the state decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_out_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_out_decode
// Description : Purely combinational state-to-control-word decoder for the
//               multicycle control FSM. Add-immediate states are decoded only
//               when MULTICYCLE_ADDI_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore decode: every field defaults to 0, each state raises its own terms
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load once the fetch actually completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
`else
      // Without the add-immediate feature these encodings are inert
      S_ADDI_EXEC, S_ADDI_WB: begin
        ctrl = '0;
      end
`endif
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle datapath. Holds the state
//               register and next-state logic, stalls on memory via
//               mem_ready, flags unknown opcodes, and gates every output to 0
//               while rst_n is low. Define MULTICYCLE_ADDI_EN to add the
//               add-immediate instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state;
  state_t next_state;
  logic   illegal;
  ctrl_t  ctrl;

  // Zero is combined with PCWriteCond by the datapath, not by this FSM
  logic   unused_zero;
  assign unused_zero = Zero;

  // State register with synchronous active-low reset to FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; Opcode is consulted only in DECODE and MEM_ADDR
  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (state)
      S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      next_state = S_ADDI_EXEC;
`endif
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  next_state = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   next_state = S_R_WB;
      S_R_WB:      next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_ADDI_WB:   next_state = S_FETCH;
`else
      S_ADDI_EXEC, S_ADDI_WB: next_state = S_FETCH;
`endif
      default:     next_state = S_FETCH;
    endcase
  end

  mc_out_decode u_out_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Outputs forced low while reset is held so nothing writes during reset
  always_comb begin
    PCWrite     = rst_n & ctrl.pc_write;
    PCWriteCond = rst_n & ctrl.pc_write_cond;
    IorD        = rst_n & ctrl.i_or_d;
    MemRead     = rst_n & ctrl.mem_read;
    MemWrite    = rst_n & ctrl.mem_write;
    MemtoReg    = rst_n & ctrl.mem_to_reg;
    IRWrite     = rst_n & ctrl.ir_write;
    PCSource    = {2{rst_n}} & ctrl.pc_source;
    ALUOp       = {2{rst_n}} & ctrl.alu_op;
    ALUSrcA     = rst_n & ctrl.alu_src_a;
    ALUSrcB     = {2{rst_n}} & ctrl.alu_src_b;
    RegWrite    = rst_n & ctrl.reg_write;
    RegDst      = rst_n & ctrl.reg_dst;
    illegal_op  = rst_n & illegal;
    state_o     = rst_n ? state : 4'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control. Each
//               step compares the state and the full packed control word
//               against hand-written per-state constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state_o;

  int pass_cnt;
  int total_cnt;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Opcode      (Opcode),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .illegal_op  (illegal_op),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  //               PCSource[1:0] ALUOp[1:0] ALUSrcA ALUSrcB[1:0] RegWrite RegDst illegal_op
  localparam logic [16:0] V_ZERO    = 17'b0_0_0_0_0_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] V_F_RDY   = 17'b1_0_0_1_0_0_1_00_00_0_01_0_0_0;
  localparam logic [16:0] V_F_STALL = 17'b0_0_0_1_0_0_0_00_00_0_01_0_0_0;
  localparam logic [16:0] V_DEC     = 17'b0_0_0_0_0_0_0_00_00_0_11_0_0_0;
  localparam logic [16:0] V_DEC_ILL = 17'b0_0_0_0_0_0_0_00_00_0_11_0_0_1;
  localparam logic [16:0] V_MADDR   = 17'b0_0_0_0_0_0_0_00_00_1_10_0_0_0;
  localparam logic [16:0] V_MRD     = 17'b0_0_1_1_0_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] V_MWB     = 17'b0_0_0_0_0_1_0_00_00_0_00_1_0_0;
  localparam logic [16:0] V_MWR     = 17'b0_0_1_0_1_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] V_EXE     = 17'b0_0_0_0_0_0_0_00_10_1_00_0_0_0;
  localparam logic [16:0] V_RWB     = 17'b0_0_0_0_0_0_0_00_00_0_00_1_1_0;
  localparam logic [16:0] V_BR      = 17'b0_1_0_0_0_0_0_01_01_1_00_0_0_0;
  localparam logic [16:0] V_J       = 17'b1_0_0_0_0_0_0_10_00_0_00_0_0_0;
  localparam logic [16:0] V_AEX     = 17'b0_0_0_0_0_0_0_00_00_1_10_0_0_0;
  localparam logic [16:0] V_AWB     = 17'b0_0_0_0_0_0_0_00_00_0_00_1_0_0;

  logic [16:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op};

  // Check state and control word mid-cycle, then advance one full clock
  task automatic step(input logic [3:0] exp_state, input logic [16:0] exp_outs,
                      input string tag);
    #1;
    total_cnt++;
    assert (state_o === exp_state) pass_cnt++;
    else $error("FAIL %s state: observed %0d expected %0d", tag, state_o, exp_state);
    total_cnt++;
    assert (outs === exp_outs) pass_cnt++;
    else $error("FAIL %s outputs: observed %b expected %b", tag, outs, exp_outs);
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    Opcode    = 6'b000000;
    Zero      = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles: everything low
    step(4'd0, V_ZERO, "rst0");
    step(4'd0, V_ZERO, "rst1");
    step(4'd0, V_ZERO, "rst2");
    rst_n = 1'b1;
    step(4'd0, V_F_RDY, "rst_release_fetch");

    // R-type: 0,1,6,7,0
    Opcode = 6'b000000;
    step(4'd1, V_DEC, "r_dec");
    Opcode = 6'b111111;  // ignored outside DECODE/MEM_ADDR
    step(4'd6, V_EXE, "r_exe");
    step(4'd7, V_RWB, "r_wb");
    step(4'd0, V_F_RDY, "r_fetch");

    // lw with two stall cycles in MEM_READ: 0,1,2,3,3,3,4,0
    Opcode = 6'b100011;
    step(4'd1, V_DEC, "lw_dec");
    step(4'd2, V_MADDR, "lw_addr");
    mem_ready = 1'b0;
    step(4'd3, V_MRD, "lw_rd_stall0");
    step(4'd3, V_MRD, "lw_rd_stall1");
    mem_ready = 1'b1;
    step(4'd3, V_MRD, "lw_rd_done");
    step(4'd4, V_MWB, "lw_wb");
    step(4'd0, V_F_RDY, "lw_fetch");

    // beq taken and not taken: identical control
    Opcode = 6'b000100;
    Zero   = 1'b1;
    step(4'd1, V_DEC, "beq1_dec");
    step(4'd8, V_BR, "beq1_br");
    step(4'd0, V_F_RDY, "beq1_fetch");
    Zero   = 1'b0;
    step(4'd1, V_DEC, "beq0_dec");
    step(4'd8, V_BR, "beq0_br");
    step(4'd0, V_F_RDY, "beq0_fetch");

    // jump
    Opcode = 6'b000010;
    step(4'd1, V_DEC, "j_dec");
    step(4'd9, V_J, "j_jump");

    // Fetch stall then illegal opcode
    mem_ready = 1'b0;
    step(4'd0, V_F_STALL, "fetch_stall");
    mem_ready = 1'b1;
    step(4'd0, V_F_RDY, "fetch_rdy");
    Opcode = 6'b111111;
    step(4'd1, V_DEC_ILL, "ill_dec");
    step(4'd0, V_F_RDY, "ill_fetch");

    // addi
    Opcode = 6'b001000;
`ifdef MULTICYCLE_ADDI_EN
    step(4'd1, V_DEC, "addi_dec");
    step(4'd10, V_AEX, "addi_exec");
    step(4'd11, V_AWB, "addi_wb");
`else
    step(4'd1, V_DEC_ILL, "addi_ill_dec");
`endif
    step(4'd0, V_F_RDY, "addi_fetch");

    // sw with stall, reset asserted during MEM_WRITE stall
    Opcode = 6'b101011;
    step(4'd1, V_DEC, "sw_dec");
    step(4'd2, V_MADDR, "sw_addr");
    mem_ready = 1'b0;
    step(4'd5, V_MWR, "sw_wr_stall0");
    step(4'd5, V_MWR, "sw_wr_stall1");
    rst_n = 1'b0;
    step(4'd0, V_ZERO, "sw_rst_comb");
    step(4'd0, V_ZERO, "sw_rst_edge");
    rst_n = 1'b1;
    step(4'd0, V_F_STALL, "sw_rst_back_fetch");
    mem_ready = 1'b1;
    step(4'd0, V_F_RDY, "post_rst_fetch");

    // Full sw without stall: 4 cycles
    step(4'd1, V_DEC, "sw2_dec");
    step(4'd2, V_MADDR, "sw2_addr");
    step(4'd5, V_MWR, "sw2_wr");
    step(4'd0, V_F_RDY, "sw2_fetch");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
